// File: rtl/pa_risc_pkg.sv
// Shared definitions for the PA-RISC pipeline control logic:
// forwarding select codes, control FSM states and register address width.
package pa_risc_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_LUSTALL = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding matcher: picks the youngest stage writing the
// operand (EX > MEM > WB); GR0 is hardwired zero and never forwarded.
module fwd_select
    import pa_risc_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] i_rs,
    input  logic          i_use,
    input  logic [AW-1:0] i_ex_rd,
    input  logic [AW-1:0] i_mem_rd,
    input  logic [AW-1:0] i_wb_rd,
    input  logic          i_ex_le,
    input  logic          i_mem_le,
    input  logic          i_wb_le,
    output logic [1:0]    o_sel,
    output logic          o_ex_hit
);

    logic w_ok;
    logic w_ex;
    logic w_mem;
    logic w_wb;

    assign w_ok  = i_use && (i_rs != '0);
    assign w_ex  = w_ok && i_ex_le  && (i_ex_rd  == i_rs);
    assign w_mem = w_ok && i_mem_le && (i_mem_rd == i_rs);
    assign w_wb  = w_ok && i_wb_le  && (i_wb_rd  == i_rs);

    always_comb begin
        if (w_ex) begin
            o_sel = FWD_EX;
        end else if (w_mem) begin
            o_sel = FWD_MEM;
        end else if (w_wb) begin
            o_sel = FWD_WB;
        end else begin
            o_sel = FWD_RF;
        end
    end

    assign o_ex_hit = w_ex;

endmodule

// File: rtl/hazard_branch_ctrl.sv
// Pipeline control: operand forwarding, load-use bubble, ID-stage branch
// steering with PA-RISC delay-slot nullification, and debug event counters.
module hazard_branch_ctrl #(
    parameter int REG_AW = pa_risc_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_ra,
    input  logic [REG_AW-1:0] id_rb,
    input  logic              id_use_ra,
    input  logic              id_use_rb,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              ex_rf_le,
    input  logic              mem_rf_le,
    input  logic              wb_rf_le,
    input  logic              ex_is_load,
    input  logic              id_branch,
    input  logic              id_cond,
    input  logic              id_taken,
    input  logic              id_backward,
    input  logic              id_n,
    input  logic              dmem_wait,
    output logic              pc_le,
    output logic              ifid_le,
    output logic              ifid_clr,
    output logic              cu_nop,
    output logic              ta_sel,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  null_cnt
);
    import pa_risc_pkg::*;

    state_t             r_state;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_null_cnt;
    logic [1:0]         w_fwd_a;
    logic [1:0]         w_fwd_b;
    logic               w_ex_a;
    logic               w_ex_b;
    logic               w_hazard;
    logic               w_taken;
    logic               w_null;

    fwd_select #(.AW(REG_AW)) u_fwd_a (
        .i_rs     (id_ra),
        .i_use    (id_use_ra),
        .i_ex_rd  (ex_rd),
        .i_mem_rd (mem_rd),
        .i_wb_rd  (wb_rd),
        .i_ex_le  (ex_rf_le),
        .i_mem_le (mem_rf_le),
        .i_wb_le  (wb_rf_le),
        .o_sel    (w_fwd_a),
        .o_ex_hit (w_ex_a)
    );

    fwd_select #(.AW(REG_AW)) u_fwd_b (
        .i_rs     (id_rb),
        .i_use    (id_use_rb),
        .i_ex_rd  (ex_rd),
        .i_mem_rd (mem_rd),
        .i_wb_rd  (wb_rd),
        .i_ex_le  (ex_rf_le),
        .i_mem_le (mem_rf_le),
        .i_wb_le  (wb_rf_le),
        .o_sel    (w_fwd_b),
        .o_ex_hit (w_ex_b)
    );

    // In LUSTALL the load has moved to MEM, so no second check is needed.
    assign w_hazard = (r_state == ST_RUN) && ex_is_load && (w_ex_a || w_ex_b);
    assign w_taken  = !id_cond || id_taken;
    assign w_null   = id_n && (!id_cond || (w_taken ^ id_backward));

    always_comb begin
        pc_le    = 1'b1;
        ifid_le  = 1'b1;
        cu_nop   = 1'b0;
        ta_sel   = 1'b0;
        ifid_clr = 1'b0;
        if (reset) begin
            pc_le   = 1'b0;
            ifid_le = 1'b0;
            cu_nop  = 1'b1;
        end else if (dmem_wait) begin
            pc_le   = 1'b0;
            ifid_le = 1'b0;
        end else if (w_hazard) begin
            pc_le   = 1'b0;
            ifid_le = 1'b0;
            cu_nop  = 1'b1;
        end else if (id_branch) begin
            ta_sel   = w_taken;
            ifid_clr = w_null;
        end
    end

    assign fwd_a = reset ? FWD_RF : w_fwd_a;
    assign fwd_b = reset ? FWD_RF : w_fwd_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_null_cnt  <= '0;
        end else if (!dmem_wait) begin
            r_state <= w_hazard ? ST_LUSTALL : ST_RUN;
            if (w_hazard) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (ifid_clr) begin
                r_null_cnt <= r_null_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign null_cnt  = r_null_cnt;

endmodule
